// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: size codes,
// FSM/grant encodings, memory-mapped I/O addresses and bus widths.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [ADDR_W-1:0] IO_ADDR_0 = 32'h0003_0000;
    localparam logic [ADDR_W-1:0] IO_ADDR_1 = 32'h0003_0004;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;
    typedef enum logic [1:0] {GNT_FETCH = 2'd1, GNT_LSB = 2'd2} grant_t;

    // Size code 3 is illegal and is handled as a full word.
    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] addr);
        return (addr == IO_ADDR_0) || (addr == IO_ADDR_1);
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetches and LSB
// loads/stores onto an 8-bit memory port, one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_fetch_valid,
    input  logic [ADDR_W-1:0] in_fetch_addr,
    output logic              out_fetch_done,
    output logic [DATA_W-1:0] out_fetch_data,
    input  logic              in_lsb_valid,
    input  logic              in_lsb_wr,
    input  logic [1:0]        in_lsb_size,
    input  logic [ADDR_W-1:0] in_lsb_addr,
    input  logic [DATA_W-1:0] in_lsb_wdata,
    output logic              out_lsb_done,
    output logic [DATA_W-1:0] out_lsb_data,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              in_rob_misbranch
);

    state_t            state, state_n;
    grant_t            last_gnt;
    logic [2:0]        cnt, len, lane;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rbuf, rdata_n;
    logic [BYTE_W-1:0] wbyte;
    logic              lsb_ok, pick_fetch, pick_lsb, last, abort;

    always_comb begin
        // An I/O store must wait while the output buffer is full.
        lsb_ok     = in_lsb_valid && !(in_lsb_wr && is_io(in_lsb_addr) && io_buffer_full);
        pick_fetch = in_fetch_valid && (!lsb_ok || last_gnt == GNT_LSB);
        pick_lsb   = lsb_ok && !pick_fetch;
        last       = (cnt == len);
        abort      = (state == S_FETCH || state == S_LOAD) && in_rob_misbranch;
        state_n    = state;
        case (state)
            S_IDLE: begin
                if (!in_rob_misbranch) begin
                    if (pick_fetch)    state_n = S_FETCH;
                    else if (pick_lsb) state_n = in_lsb_wr ? S_STORE : S_LOAD;
                end
            end
            S_FETCH, S_LOAD: if (abort || last) state_n = S_IDLE;
            S_STORE:         if (last) state_n = S_IDLE;
            default:         state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= S_IDLE;
        else if (rdy) state <= state_n;
    end

    // Byte returned now belongs to the address issued one cycle earlier.
    always_comb begin
        lane    = cnt - 3'd1;
        rdata_n = rbuf;
        for (int i = 0; i < 4; i++)
            if (lane == 3'(i)) rdata_n[8*i +: 8] = mem_din;
        wbyte = wdata_q[{cnt[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            len            <= '0;
            last_gnt       <= GNT_FETCH;
            addr_q         <= '0;
            wdata_q        <= '0;
            rbuf           <= '0;
            mem_a          <= '0;
            mem_dout       <= '0;
            mem_wr         <= 1'b0;
            out_fetch_done <= 1'b0;
            out_lsb_done   <= 1'b0;
            out_fetch_data <= '0;
            out_lsb_data   <= '0;
        end else begin
            out_fetch_done <= 1'b0;
            out_lsb_done   <= 1'b0;
            if (rdy) begin
                if (state == S_IDLE) begin
                    cnt    <= '0;
                    rbuf   <= '0;
                    mem_wr <= 1'b0;
                    if (state_n == S_FETCH) begin
                        addr_q   <= in_fetch_addr;
                        len      <= 3'd4;
                        last_gnt <= GNT_FETCH;
                    end else if (state_n != S_IDLE) begin
                        addr_q   <= in_lsb_addr;
                        wdata_q  <= in_lsb_wdata;
                        len      <= size_len(in_lsb_size);
                        last_gnt <= GNT_LSB;
                    end
                end else if (abort) begin
                    cnt    <= '0;
                    mem_wr <= 1'b0;
                end else begin
                    if (state != S_STORE && cnt != 3'd0) rbuf <= rdata_n;
                    if (!last) begin
                        mem_a  <= addr_q + 32'(cnt);
                        mem_wr <= (state == S_STORE);
                        if (state == S_STORE) mem_dout <= wbyte;
                        cnt    <= cnt + 3'd1;
                    end else begin
                        cnt    <= '0;
                        mem_wr <= 1'b0;
                        case (state)
                            S_FETCH: begin
                                out_fetch_done <= 1'b1;
                                out_fetch_data <= rdata_n;
                            end
                            S_LOAD: begin
                                out_lsb_done <= 1'b1;
                                out_lsb_data <= rdata_n;
                            end
                            default: out_lsb_done <= 1'b1;
                        endcase
                    end
                end
            end
        end
    end

endmodule
